// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if
//   Command side of the CPU data-RAM port: word address plus read and write
//   strobes. The shared data bus itself is a plain inout on the responder,
//   so that tristate resolution stays at module boundaries.
//
//   Signals:
//     address_to_ram       word address from the CPU
//     read_enable_to_ram   CPU read strobe
//     write_enable_to_ram  CPU write strobe (CPU drives the data bus while high)
//
//   Modports: master (CPU side, drives the strobes), slave (memory side).
interface data_ram_responder_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] address_to_ram;
    logic                  read_enable_to_ram;
    logic                  write_enable_to_ram;

    modport master (
        output address_to_ram,
        output read_enable_to_ram,
        output write_enable_to_ram
    );

    modport slave (
        input address_to_ram,
        input read_enable_to_ram,
        input write_enable_to_ram
    );
endinterface

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Data-memory responder for the CPU RAM port: a 2**ADDR_WIDTH x DATA_WIDTH
//   store. Reads drive the shared bus combinationally from the address;
//   writes commit on the rising clock edge. Adds a sticky read/write
//   conflict flag and saturating read/write counters.
//
//   Optional feature macro: DATA_RAM_INIT_EN
//     defined   : after reset an INIT sequencer fills mem[i] = 2*i over
//                 2**ADDR_WIDTH edges, then the block becomes ready.
//     undefined : no fill; the block is ready after the first edge following
//                 reset release and memory content is undefined until written.
//
//   Ports:
//     clk             system clock, rising edge
//     reset           asynchronous, active-high reset
//     bus             command interface (address, read/write strobes), slave side
//     data_ram        shared bidirectional data bus; driven here only on a
//                     serviced read
//     ram_ready       high while accesses are serviced
//     conflict_error  sticky: read and write strobes seen together while ready
//     read_count      saturating count of serviced read cycles
//     write_count     saturating count of committed writes
module data_ram_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    data_ram_responder_if.slave    bus,
    inout  wire [DATA_WIDTH-1:0]   data_ram,
    output logic                   ram_ready,
    output logic                   conflict_error,
    output logic [15:0]            read_count,
    output logic [15:0]            write_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {INIT, READY} state_t;

    state_t state_reg, state_next;
    logic        conflict_reg, conflict_next;
    logic [15:0] rd_cnt_reg, rd_cnt_next;
    logic [15:0] wr_cnt_reg, wr_cnt_next;

`ifdef DATA_RAM_INIT_EN
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
`endif

    // Storage is deliberately not reset; the fill sequencer (when present)
    // supplies known contents.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Access decode; strobes only count once the block is ready.
    logic rd_only, wr_only, rd_wr_both;
    assign rd_only    = (state_reg == READY) &&  bus.read_enable_to_ram && !bus.write_enable_to_ram;
    assign wr_only    = (state_reg == READY) && !bus.read_enable_to_ram &&  bus.write_enable_to_ram;
    assign rd_wr_both = (state_reg == READY) &&  bus.read_enable_to_ram &&  bus.write_enable_to_ram;

    // Zero-latency read: bus follows the address combinationally and is
    // released as soon as the read strobe drops or a write joins it.
    assign data_ram = rd_only ? mem[bus.address_to_ram] : {DATA_WIDTH{1'bz}};

    assign ram_ready      = (state_reg == READY);
    assign conflict_error = conflict_reg;
    assign read_count     = rd_cnt_reg;
    assign write_count    = wr_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= INIT;
            conflict_reg <= 1'b0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
`ifdef DATA_RAM_INIT_EN
            idx_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            conflict_reg <= conflict_next;
            rd_cnt_reg   <= rd_cnt_next;
            wr_cnt_reg   <= wr_cnt_next;
`ifdef DATA_RAM_INIT_EN
            idx_reg      <= idx_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        conflict_next = conflict_reg;
        rd_cnt_next   = rd_cnt_reg;
        wr_cnt_next   = wr_cnt_reg;
        mem_we        = 1'b0;
        mem_waddr     = bus.address_to_ram;
        mem_wdata     = data_ram;
`ifdef DATA_RAM_INIT_EN
        idx_next      = idx_reg;
`endif
        case (state_reg)
            INIT: begin
`ifdef DATA_RAM_INIT_EN
                // One word per edge: mem[idx] = 2*idx, truncated to the word.
                mem_we    = 1'b1;
                mem_waddr = idx_reg;
                mem_wdata = DATA_WIDTH'({idx_reg, 1'b0});
                idx_next  = idx_reg + 1'b1;
                if (idx_reg == {ADDR_WIDTH{1'b1}}) begin
                    state_next = READY;
                end
`else
                state_next = READY;
`endif
            end
            READY: begin
                if (rd_wr_both) begin
                    conflict_next = 1'b1;
                end else if (rd_only) begin
                    if (rd_cnt_reg != 16'hFFFF) begin
                        rd_cnt_next = rd_cnt_reg + 16'd1;
                    end
                end else if (wr_only) begin
                    mem_we = 1'b1;
                    if (wr_cnt_reg != 16'hFFFF) begin
                        wr_cnt_next = wr_cnt_reg + 16'd1;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder
//   Directed bench for data_ram_responder. Follows the DATA_RAM_INIT_EN
//   setting of the build: with the macro the fill sequence, INIT-time
//   lockout and reset-mid-fill are exercised; without it the immediate
//   ready path. Both builds cover reads, writes, conflict and reset.
//   Inputs change on the falling edge; outputs are sampled either a few ns
//   later (combinational bus) or 1 ns after the rising edge (registers).
module tb_data_ram_responder;
    logic clk;
    logic reset;
    logic tb_drv;
    logic [15:0] tb_val;
    wire  [15:0] data_ram;
    logic        ram_ready;
    logic        conflict_error;
    logic [15:0] read_count;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    data_ram_responder_if #(.ADDR_WIDTH(6)) bus_if ();

    assign data_ram = tb_drv ? tb_val : 16'hzzzz;

    data_ram_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if.slave),
        .data_ram       (data_ram),
        .ram_ready      (ram_ready),
        .conflict_error (conflict_error),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // An undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
    function automatic logic bus_released(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic idle();
        @(negedge clk);
        bus_if.read_enable_to_ram  = 1'b0;
        bus_if.write_enable_to_ram = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [15:0] val);
        @(negedge clk);
        bus_if.address_to_ram      = addr;
        bus_if.read_enable_to_ram  = 1'b0;
        bus_if.write_enable_to_ram = 1'b1;
        tb_val = val;
        tb_drv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus_if.address_to_ram      = addr;
        bus_if.write_enable_to_ram = 1'b0;
        bus_if.read_enable_to_ram  = 1'b1;
        tb_drv = 1'b0;
        #2;
        check16(tag, data_ram, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check16({tag, "_ready"},    {15'd0, ram_ready}, 16'd0);
        check16({tag, "_conflict"}, {15'd0, conflict_error}, 16'd0);
        check16({tag, "_rcount"},   read_count, 16'd0);
        check16({tag, "_wcount"},   write_count, 16'd0);
        check16({tag, "_bus_z"},    {15'd0, bus_released(data_ram)}, 16'd1);
    endtask

    initial begin
        reset = 1'b1;
        tb_drv = 1'b0;
        tb_val = 16'h0000;
        bus_if.address_to_ram      = '0;
        bus_if.read_enable_to_ram  = 1'b0;
        bus_if.write_enable_to_ram = 1'b0;

        // Hold reset until the falling edge at 140 ns.
        repeat (7) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

`ifdef DATA_RAM_INIT_EN
        // Edges 1..10 fill idx 0..9; CPU accesses at idx 10 must be ignored.
        repeat (10) @(posedge clk);
        do_write(6'd0, 16'hFFFF);
        check16("init_wcount", write_count, 16'd0);
        @(negedge clk);
        bus_if.write_enable_to_ram = 1'b0;
        tb_drv = 1'b0;
        bus_if.address_to_ram      = 6'd1;
        bus_if.read_enable_to_ram  = 1'b1;
        #2;
        check16("init_read_bus_z", {15'd0, bus_released(data_ram)}, 16'd1);
        @(posedge clk);
        #1;
        check16("init_rcount", read_count, 16'd0);
        idle();
        // 12 edges used; ready must still be low after edge 63, high after 64.
        repeat (51) @(posedge clk);
        #1;
        check16("fill_ready_63", {15'd0, ram_ready}, 16'd0);
        @(posedge clk);
        #1;
        check16("fill_ready_64", {15'd0, ram_ready}, 16'd1);

        do_read(6'd5,  16'h000A, "read_addr5");
        do_read(6'd63, 16'h007E, "read_addr63");
        idle();
        check16("rcount_2", read_count, 16'd2);
        do_read(6'd0,  16'h0000, "init_write_ignored");

        do_write(6'd3, 16'h1234);
        do_read(6'd3,  16'h1234, "readback_addr3");
        check16("wcount_1", write_count, 16'd1);
        do_read(6'd4,  16'h0008, "neighbour_addr4");
        idle();
        check16("rcount_5", read_count, 16'd5);

        // Conflict at addr 7: CPU drives BEEF, RAM must neither drive nor write.
        @(negedge clk);
        bus_if.address_to_ram      = 6'd7;
        bus_if.read_enable_to_ram  = 1'b1;
        bus_if.write_enable_to_ram = 1'b1;
        tb_val = 16'hBEEF;
        tb_drv = 1'b1;
        #2;
        check16("conflict_bus", data_ram, 16'hBEEF);
        @(posedge clk);
        #1;
        check16("conflict_flag", {15'd0, conflict_error}, 16'd1);
        check16("conflict_rcount", read_count, 16'd5);
        check16("conflict_wcount", write_count, 16'd1);
        do_read(6'd7, 16'h000E, "conflict_no_write");
        idle();
        check16("conflict_sticky", {15'd0, conflict_error}, 16'd1);
        check16("rcount_6", read_count, 16'd6);

        // Reset partway into a refill, then confirm a complete fresh fill.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_ready");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check16("midinit_ready", {15'd0, ram_ready}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        check16("refill_ready_63", {15'd0, ram_ready}, 16'd0);
        @(posedge clk);
        #1;
        check16("refill_ready_64", {15'd0, ram_ready}, 16'd1);
        for (int i = 0; i < 64; i++) begin
            do_read(i[5:0], 16'(2 * i), "refill_word");
        end
        idle();
        check16("refill_rcount", read_count, 16'd64);
`else
        #1;
        check16("noinit_ready_0", {15'd0, ram_ready}, 16'd0);
        @(posedge clk);
        #1;
        check16("noinit_ready_1", {15'd0, ram_ready}, 16'd1);

        do_write(6'd9, 16'h0055);
        do_read(6'd9,  16'h0055, "readback_addr9");
        do_write(6'd3, 16'h1234);
        do_write(6'd7, 16'h000E);
        do_read(6'd3,  16'h1234, "readback_addr3");
        idle();
        check16("wcount_3", write_count, 16'd3);
        check16("rcount_2", read_count, 16'd2);

        @(negedge clk);
        bus_if.address_to_ram      = 6'd7;
        bus_if.read_enable_to_ram  = 1'b1;
        bus_if.write_enable_to_ram = 1'b1;
        tb_val = 16'hBEEF;
        tb_drv = 1'b1;
        #2;
        check16("conflict_bus", data_ram, 16'hBEEF);
        @(posedge clk);
        #1;
        check16("conflict_flag", {15'd0, conflict_error}, 16'd1);
        check16("conflict_wcount", write_count, 16'd3);
        do_read(6'd7, 16'h000E, "conflict_no_write");
        idle();
        check16("conflict_sticky", {15'd0, conflict_error}, 16'd1);
        check16("rcount_3", read_count, 16'd3);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_ready");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check16("reready", {15'd0, ram_ready}, 16'd1);
        do_read(6'd9, 16'h0055, "mem_kept_over_reset");
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Data-memory responder on the CPU's RAM port: a 64 x 16 store that answers the CPU's address/read-enable/write-enable strobes over the shared bidirectional `data_ram` bus. Reads drive the bus combinationally so the CPU sees data in the same cycle. Writes commit on the clock edge. A post-reset initialisation sequencer, a sticky conflict flag and saturating access counters make it the synthesizable replacement for the behavioural memory model used in CPU simulation.

## Interface
- `DATA_WIDTH`, 16, word width of storage and bus
- `ADDR_WIDTH`, 6, address width; depth = 2**ADDR_WIDTH = 64
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `address_to_ram`  in  ADDR_WIDTH  word address from CPU
- `read_enable_to_ram`  in  1  CPU read strobe
- `write_enable_to_ram`  in  1  CPU write strobe; CPU drives `data_ram` while high
- `data_ram`  inout  DATA_WIDTH  shared data bus; driven by this block only on a valid read
- `ram_ready`  out  1  high when accesses are serviced
- `conflict_error`  out  1  sticky; read and write seen together
- `read_count`  out  16  saturating count of serviced read cycles
- `write_count`  out  16  saturating count of committed writes

## Operation
- States: INIT, READY. Reset forces INIT, fill index 0, `ram_ready`=0, `conflict_error`=0, both counters 0, bus released (Z). Memory array itself is not reset.
- INIT: each rising edge writes mem[idx] = 2*idx (truncated to DATA_WIDTH), idx increments. The edge that writes idx 63 moves the block to READY.
- READY, read only (`read_enable_to_ram`=1, write=0): `data_ram` = mem[address_to_ram], combinational from address. `read_count` increments at each rising edge where this holds.
- READY, write only: mem[address_to_ram] <= `data_ram` at the rising edge. `write_count` increments. Bus not driven by this block.
- READY, both strobes high: conflict. Bus not driven, no write, no counter change. `conflict_error` set at that edge and held until reset.
- Neither strobe: bus Z, no state change.
- INIT: all CPU strobes are ignored. Bus Z, no writes from bus, counters frozen, no conflict detection.
- Counters saturate at 16'hFFFF.
- Reset mid-INIT or mid-READY: immediate return to INIT, idx 0. Full fill restarts on release.

## Timing
- Read latency 0 cycles: data is valid one combinational delay after address/enable settle. Bus release is combinational on enable drop.
- Write latency 1 edge: a read of the same address in the following cycle returns the new value.
- `ram_ready` rises after the 64th rising edge following reset release, and is registered.
- `conflict_error` and the counters are registered and update at the same edge as the access.
- All outputs are asynchronously forced to their reset values while `reset`=1.

## Configuration
- `DATA_RAM_INIT_EN` defined: INIT sequencer present as described, with 64-cycle fill of mem[i]=2*i.
- Not defined: no sequencer and no fill. Block enters READY at the first rising edge after reset release (`ram_ready`=1 after that edge). Memory contents are undefined until written. All other behaviour is identical.

## Test plan
- Fill (macro on): release reset at 140 ns, 20 ns clock → `ram_ready` low for 63 edges, high after the 64th edge. Read addr 5 → 16'h000A. Read addr 63 → 16'h007E. `read_count`=2.
- Write/readback: write 16'h1234 to addr 3, then read addr 3 next cycle → 16'h1234. `write_count`=1. Addr 4 still reads 16'h0008.
- Conflict: both strobes high at addr 7, CPU driving 16'hBEEF → bus not driven by RAM, mem[7] stays 16'h000E. `conflict_error`=1 and remains 1 through later clean accesses until reset.
- Access during INIT: write 16'hFFFF to addr 0 and read addr 1 at idx 10 → bus Z, counters 0. After READY, addr 0 reads 16'h0000.
- Reset mid-INIT: assert reset at idx 20, release → `ram_ready` 0, rises again exactly 64 edges after the new release. All words hold 2*i.
- Macro off: after reset release, `ram_ready`=1 after the first edge. Write 16'h0055 to addr 9, read back → 16'h0055.
